ex_mem_pipe_skid: RTL and testbench

Parametrised EX→MEM pipeline register carrying control bits, an ALU/store payload and a destination-register index.
Adds a valid/ready handshake, backpressure (stall), synchronous flush and an optional 2-entry skid buffer, so MEM-stage stalls never combinationally load EX-stage ready.
Sits between the EX datapath and the data-memory interface; the hazard unit drives flush_i and observes occupancy_o.

---
 rtl/core_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 42 ++++
 rtl/ex_mem_pipe_skid.sv | 111 +++++++++++
 tb/tb_ex_mem_pipe_skid.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: control-bit positions, widths and the
// EX/MEM control bundle.
package core_pkg;

   localparam int REGWRITE   = 0;
   localparam int MEMTOREG   = 1;
   localparam int MEMREAD    = 2;
   localparam int MEMWRITE   = 3;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic memWrite;
      logic memRead;
      logic memtoReg;
      logic regWrite;
   } exMemCtrl_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid + ctrl + payload + rd.
// Clearing zeroes ctrl and rd so an empty entry can never write state.
module pipe_entry_reg
   import core_pkg::*;
#(
   parameter int CTRL_W = $bits(exMemCtrl_t),
   parameter int DATA_W = 2 * XLEN,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] rd_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] rd_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_o <= 1'b0;
         ctrl_o  <= '0;
         data_o  <= '0;
         rd_o    <= '0;
      end else if (clr_i) begin
         // payload is kept: it is don't-care while invalid
         valid_o <= 1'b0;
         ctrl_o  <= '0;
         rd_o    <= '0;
      end else if (ld_i) begin
         valid_o <= 1'b1;
         ctrl_o  <= ctrl_i;
         data_o  <= data_i;
         rd_o    <= rd_i;
      end
   end

endmodule

// File: rtl/ex_mem_pipe_skid.sv
// EX->MEM pipeline register with valid/ready handshake, flush and an
// optional skid entry that keeps in_ready_o off the MEM ready path.
module ex_mem_pipe_skid
   import core_pkg::*;
#(
   parameter int CTRL_W = $bits(exMemCtrl_t),
   parameter int DATA_W = 2 * XLEN,
   parameter int ADDR_W = REG_ADDR_W,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] rd_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] rd_o,
   output logic [1:0]        occupancy_o
);

   logic              mainValid;
   logic              skidValid;
   logic [CTRL_W-1:0] skidCtrl;
   logic [DATA_W-1:0] skidData;
   logic [ADDR_W-1:0] skidRd;
   logic              accept;
   logic              fire;
   logic              mainLd;
   logic              mainClr;
   logic [CTRL_W-1:0] mainCtrlIn;
   logic [DATA_W-1:0] mainDataIn;
   logic [ADDR_W-1:0] mainRdIn;

   assign accept = in_valid_i & in_ready_o;
   assign fire   = mainValid & out_ready_i;

   // skid has priority into main: it holds the older entry
   assign mainLd  = ~flush_i
                  & ((skidValid & fire)
                   | (accept & (~mainValid | fire)));
   assign mainClr = flush_i | (fire & ~mainLd);

   assign mainCtrlIn = skidValid ? skidCtrl : ctrl_i;
   assign mainDataIn = skidValid ? skidData : data_i;
   assign mainRdIn   = skidValid ? skidRd   : rd_i;

   pipe_entry_reg #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (mainClr),
      .ld_i    (mainLd),
      .ctrl_i  (mainCtrlIn),
      .data_i  (mainDataIn),
      .rd_i    (mainRdIn),
      .valid_o (mainValid),
      .ctrl_o  (ctrl_o),
      .data_o  (data_o),
      .rd_o    (rd_o)
   );

   generate
      if (SKID) begin : gSkid
         logic skidLd;
         logic skidClr;

         assign skidLd  = ~flush_i & accept & mainValid & ~fire;
         assign skidClr = flush_i | (skidValid & fire);

         pipe_entry_reg #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
         ) u_skid (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (skidClr),
            .ld_i    (skidLd),
            .ctrl_i  (ctrl_i),
            .data_i  (data_i),
            .rd_i    (rd_i),
            .valid_o (skidValid),
            .ctrl_o  (skidCtrl),
            .data_o  (skidData),
            .rd_o    (skidRd)
         );

         // straight off a flop: no path from out_ready_i
         assign in_ready_o = ~skidValid;
      end else begin : gNoSkid
         assign skidValid  = 1'b0;
         assign skidCtrl   = '0;
         assign skidData   = '0;
         assign skidRd     = '0;
         assign in_ready_o = ~mainValid | out_ready_i;
      end
   endgenerate

   assign out_valid_o = mainValid;
   assign occupancy_o = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_ex_mem_pipe_skid.sv
// Bench for ex_mem_pipe_skid: SKID=1 and SKID=0 builds share one stimulus
// stream, each checked against its own FIFO scoreboard every cycle.
module tb_ex_mem_pipe_skid;
   import core_pkg::*;

   typedef struct {
      logic [3:0]  c;
      logic [63:0] d;
      logic [4:0]  r;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        inValid;
   logic        outReady;
   logic [3:0]  ctrlIn;
   logic [63:0] dataIn;
   logic [4:0]  rdIn;

   logic        inReady1, outValid1, inReady0, outValid0;
   logic [3:0]  ctrl1, ctrl0;
   logic [63:0] data1, data0;
   logic [4:0]  rd1, rd0;
   logic [1:0]  occ1, occ0;

   ent_t q1[$];
   ent_t q0[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_i = ~clk_i;

   ex_mem_pipe_skid #(.SKID(1'b1)) u_dut1 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady1),
      .ctrl_i      (ctrlIn),
      .data_i      (dataIn),
      .rd_i        (rdIn),
      .out_valid_o (outValid1),
      .out_ready_i (outReady),
      .ctrl_o      (ctrl1),
      .data_o      (data1),
      .rd_o        (rd1),
      .occupancy_o (occ1)
   );

   ex_mem_pipe_skid #(.SKID(1'b0)) u_dut0 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady0),
      .ctrl_i      (ctrlIn),
      .data_i      (dataIn),
      .rd_i        (rdIn),
      .out_valid_o (outValid0),
      .out_ready_i (outReady),
      .ctrl_o      (ctrl0),
      .data_o      (data0),
      .rd_o        (rd0),
      .occupancy_o (occ0)
   );

   task automatic checkVal(input string tag,
                           input logic [63:0] act,
                           input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  tag, act, exp, $time);
      end
   endtask

   task automatic checkAll();
      int n1 = q1.size();
      int n0 = q0.size();
      checkVal("skid.valid", outValid1, n1 != 0);
      checkVal("skid.occ", occ1, n1);
      checkVal("skid.ready", inReady1, n1 < 2);
      if (n1 != 0) begin
         checkVal("skid.ctrl", ctrl1, q1[0].c);
         checkVal("skid.rd", rd1, q1[0].r);
         checkVal("skid.data", data1, q1[0].d);
      end else begin
         checkVal("skid.ctrlBubble", ctrl1, 0);
         checkVal("skid.rdBubble", rd1, 0);
      end
      checkVal("noskid.valid", outValid0, n0 != 0);
      checkVal("noskid.occ", occ0, n0);
      checkVal("noskid.ready", inReady0, (n0 == 0) || outReady);
      if (n0 != 0) begin
         checkVal("noskid.ctrl", ctrl0, q0[0].c);
         checkVal("noskid.rd", rd0, q0[0].r);
         checkVal("noskid.data", data0, q0[0].d);
      end else begin
         checkVal("noskid.ctrlBubble", ctrl0, 0);
         checkVal("noskid.rdBubble", rd0, 0);
      end
   endtask

   // inputs are set at posedge+1; check mid-cycle, then update scoreboard
   task automatic cycle();
      bit   acc1, fire1, acc0, fire0;
      ent_t e;
      #2;
      checkAll();
      acc1  = inValid && (q1.size() < 2);
      fire1 = (q1.size() != 0) && outReady;
      acc0  = inValid && ((q0.size() == 0) || outReady);
      fire0 = (q0.size() != 0) && outReady;
      e.c = ctrlIn;
      e.d = dataIn;
      e.r = rdIn;
      @(posedge clk_i);
      if (flush_i) begin
         q1.delete();
         q0.delete();
      end else begin
         if (fire1) q1.delete(0);
         if (acc1) q1.push_back(e);
         if (fire0) q0.delete(0);
         if (acc0) q0.push_back(e);
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] r);
      inValid = v;
      rdIn    = r;
      ctrlIn  = r[3:0] ^ 4'hA;
      dataIn  = 64'hC0DE_0000_0000_0000 | {59'd0, r};
   endtask

   initial begin
      rst_i    = 1'b0;
      flush_i  = 1'b0;
      outReady = 1'b1;
      inValid  = 1'b1;
      ctrlIn   = 4'hF;
      dataIn   = 64'h1234;
      rdIn     = 5'd7;
      #8;
      checkAll();
      #3;
      rst_i = 1'b1;
      cycle();
      inValid = 1'b0;
      cycle();

      // streaming at full rate
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 5'(i));
         cycle();
      end
      drive(1'b0, 5'd0);
      repeat (3) cycle();

      // backpressure into the skid entry
      outReady = 1'b0;
      drive(1'b1, 5'd1);
      cycle();
      drive(1'b1, 5'd2);
      cycle();
      drive(1'b1, 5'd3);
      cycle();
      cycle();
      outReady = 1'b1;
      cycle();
      cycle();
      drive(1'b0, 5'd0);
      repeat (4) cycle();

      // flush at occupancy 2 with a competing entry
      outReady = 1'b0;
      drive(1'b1, 5'd4);
      cycle();
      drive(1'b1, 5'd5);
      cycle();
      flush_i  = 1'b1;
      outReady = 1'b1;
      drive(1'b1, 5'd9);
      cycle();
      flush_i = 1'b0;
      drive(1'b0, 5'd0);
      repeat (3) cycle();

      // combinational ready of the single-register build
      outReady = 1'b0;
      drive(1'b1, 5'd12);
      cycle();
      drive(1'b1, 5'd13);
      cycle();
      outReady = 1'b1;
      for (int i = 14; i <= 17; i++) begin
         drive(1'b1, 5'(i));
         cycle();
      end
      drive(1'b0, 5'd0);
      repeat (3) cycle();

      // async reset while stalled full
      outReady = 1'b0;
      drive(1'b1, 5'd20);
      cycle();
      drive(1'b1, 5'd21);
      cycle();
      drive(1'b0, 5'd0);
      cycle();
      #2;
      rst_i = 1'b0;
      #1;
      q1.delete();
      q0.delete();
      checkAll();
      #3;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      outReady = 1'b1;
      repeat (2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
